intr_entry_sequencer: RTL

// - CPU-side interrupt entry/exit sequencer; consumes intr_Out[5:0] from the interrupt controller and drives
//   its ISR_ld, current_ISR_num_ld and ISR_clr strobes.
// - At an instruction boundary it accepts the highest-priority request, pushes PC and flags through a

---
 rtl/intr_entry_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/intr_entry_sequencer.sv
// CPU-side interrupt entry/exit sequencer: accepts a request at an instruction boundary, pushes PC and
// flags through a stack handshake, vectors the PC, then releases the ISR on RETI.
module intr_entry_sequencer #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE  = 16'h0100,
  parameter int                VEC_SHIFT = 2,
  parameter int                PUSH_TMO  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        intr_Out,
  input  logic              int_enable,
  input  logic              instr_done,
  input  logic              reti,
  input  logic              mem_ready,
  output logic              ISR_ld,
  output logic              current_ISR_num_ld,
  output logic              ISR_clr,
  output logic              push_req,
  output logic              push_sel,
  output logic              ie_clr,
  output logic              pc_ld,
  output logic [ADDR_W-1:0] vector_addr,
  output logic [2:0]        vec_idx,
  output logic              busy,
  output logic              fault
);

  localparam int CNT_W = $clog2(PUSH_TMO + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LATCH   = 3'd1;
  localparam logic [2:0] PUSH_PC = 3'd2;
  localparam logic [2:0] PUSH_FL = 3'd3;
  localparam logic [2:0] VECTOR  = 3'd4;
  localparam logic [2:0] SERVICE = 3'd5;
  localparam logic [2:0] CLEAR   = 3'd6;

  // Bit5 is the highest priority and maps to slot 0.
  function automatic logic [2:0] prio_idx(input logic [5:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (req[i]) idx = 3'(5 - i);
    end
    return idx;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              fault_q, fault_d;
  logic [2:0]        vec_idx_q, vec_idx_d;
  logic [ADDR_W-1:0] vector_addr_q, vector_addr_d;

  logic isr_ld_q, isr_ld_d;
  logic cur_ld_q, cur_ld_d;
  logic isr_clr_q, isr_clr_d;
  logic push_req_q, push_req_d;
  logic push_sel_q, push_sel_d;
  logic ie_clr_q, ie_clr_d;
  logic pc_ld_q, pc_ld_d;
  logic busy_q, busy_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fault_d       = fault_q;
    vec_idx_d     = vec_idx_q;
    vector_addr_d = vector_addr_q;
    case (state_q)
      IDLE: begin
        if (instr_done && int_enable && (|intr_Out) && !fault_q) begin
          state_d   = LATCH;
          vec_idx_d = prio_idx(intr_Out);
        end
      end
      LATCH: begin
        vector_addr_d = VEC_BASE + (ADDR_W'(vec_idx_q) << VEC_SHIFT);
        cnt_d         = '0;
        state_d       = PUSH_PC;
      end
      PUSH_PC, PUSH_FL: begin
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = (state_q == PUSH_PC) ? PUSH_FL : VECTOR;
        end else if (cnt_inc == CNT_W'(PUSH_TMO)) begin
          // Stack never answered: abandon the entry without touching the PC.
          cnt_d   = '0;
          fault_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      VECTOR:  state_d = SERVICE;
      SERVICE: if (reti) state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    isr_ld_d   = (state_d == LATCH);
    cur_ld_d   = (state_d == LATCH);
    ie_clr_d   = (state_d == LATCH);
    push_req_d = (state_d == PUSH_PC) || (state_d == PUSH_FL);
    push_sel_d = (state_d == PUSH_FL);
    pc_ld_d    = (state_d == VECTOR);
    isr_clr_d  = (state_d == CLEAR);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      fault_q       <= 1'b0;
      vec_idx_q     <= 3'd0;
      vector_addr_q <= '0;
      isr_ld_q      <= 1'b0;
      cur_ld_q      <= 1'b0;
      isr_clr_q     <= 1'b0;
      push_req_q    <= 1'b0;
      push_sel_q    <= 1'b0;
      ie_clr_q      <= 1'b0;
      pc_ld_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fault_q       <= fault_d;
      vec_idx_q     <= vec_idx_d;
      vector_addr_q <= vector_addr_d;
      isr_ld_q      <= isr_ld_d;
      cur_ld_q      <= cur_ld_d;
      isr_clr_q     <= isr_clr_d;
      push_req_q    <= push_req_d;
      push_sel_q    <= push_sel_d;
      ie_clr_q      <= ie_clr_d;
      pc_ld_q       <= pc_ld_d;
      busy_q        <= busy_d;
    end
  end

  assign ISR_ld             = isr_ld_q;
  assign current_ISR_num_ld = cur_ld_q;
  assign ISR_clr            = isr_clr_q;
  assign push_req           = push_req_q;
  assign push_sel           = push_sel_q;
  assign ie_clr             = ie_clr_q;
  assign pc_ld              = pc_ld_q;
  assign vector_addr        = vector_addr_q;
  assign vec_idx            = vec_idx_q;
  assign busy               = busy_q;
  assign fault              = fault_q;

endmodule
